dct_transpose_buf: RTL and testbench
====================================

Name: dct_transpose_buf

Overview:
- Parametrised ping-pong transpose buffer between the first (row) and second (column) DCT stages of the JPEG 2D-DCT datapath.
- Replaces the fixed 8x8 transpose memory pair and its free-running enable toggler.
- Accepts N-element rows on a valid/ready handshake and emits N-element columns, or rows in pass-through mode, on a second valid/ready handshake.
- Two banks allow one block to be written while the other drains, giving full rate with back-pressure on both sides.

Parameters:
- N, 8, block dimension in rows/columns; N >= 2.
- ELEM_W, 8, bits per element; a row or column is N*ELEM_W bits.
- CW, $clog2(N), row/column counter width (derived; do not override).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous flush; empties both banks and zeroes all pointers.
- transpose  input  1  1 = output columns, 0 = output rows unchanged; sampled per bank.
- in_valid  input  1  in_data holds a valid row.
- in_ready  output  1  buffer can accept a row this cycle.
- in_data  input  N*ELEM_W  row; element k occupies bits [k*ELEM_W +: ELEM_W].
- out_valid  output  1  out_data holds a valid column or row.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  N*ELEM_W  column/row; element k at bits [k*ELEM_W +: ELEM_W].
- out_last  output  1  out_data is the final (N-1th) vector of the current block.
- out_first  output  1  out_data is vector 0 of the current block.

Behaviour:
- State:
  - storage bank[2][N][N*ELEM_W], not reset;
  - full[1:0];
  - mode[1:0], the per-bank transpose flag;
  - wr_bank, wr_row[CW-1:0];
  - rd_bank, rd_idx[CW-1:0].
- Reset (async) and clear (sync, same targets): full=0, wr_bank=0, rd_bank=0, wr_row=0, rd_idx=0, mode=0.
  - clear has priority over any same-cycle handshake; both handshakes in that cycle are discarded.
- Output values during and just after reset: in_ready=1, out_valid=0, out_data=0, out_last=0, out_first=0.
  - In the reset-asserted cycle in_ready follows state, so it reads 1; the handshake is ignored.
- Write side:
  - in_ready = !full[wr_bank].
  - On in_valid&&in_ready: bank[wr_bank][wr_row] <= in_data.
  - If wr_row==0, also mode[wr_bank] <= transpose.
  - If wr_row==N-1: full[wr_bank] <= 1, wr_bank toggles, wr_row <= 0.
  - Otherwise wr_row increments.
- Read side:
  - out_valid = full[rd_bank]. out_data is combinational from storage, forced to 0 when !out_valid.
  - With transpose (mode[rd_bank]=1): element r of out_data = element rd_idx of bank[rd_bank][r].
  - Pass-through (mode[rd_bank]=0): out_data = bank[rd_bank][rd_idx].
  - out_first = out_valid && rd_idx==0. out_last = out_valid && rd_idx==N-1.
  - On out_valid&&out_ready: if rd_idx==N-1 then full[rd_bank] <= 0, rd_bank toggles, rd_idx <= 0; otherwise rd_idx increments.
  - out_data, out_first and out_last remain stable while out_valid && !out_ready.
- Latency:
  - The first output vector of a block is valid the cycle after that block's Nth row is accepted.
  - With both sides always ready, steady-state throughput is one row in and one vector out per cycle, with no bubbles.
- Simultaneous events:
  - A read and a write in the same cycle always target different banks, because a write needs !full and a read needs full. Both take effect.
  - A bank freed by the last read becomes writable in the next cycle. in_ready is evaluated from the current state, with no same-cycle bypass.
  - If both banks are full, in_ready=0 until the read side finishes draining one block.
- transpose changes mid-block do not affect a block already in progress; only the value at row 0 of each block counts.
- Counters wrap only at N-1 as described; non-power-of-two N is legal.

Test Plan:
- Transpose, single block:
  - Stimulus: N=8, ELEM_W=8, transpose=1, out_ready=1. Write 8 rows with element(r,c)=8r+c; row 0 = 0x0706050403020100.
  - Response: out_valid rises 1 cycle after row 7 is accepted. Column 0 = 0x3830282018100800 with out_first=1. Column 7 = 0x3F372F271F170F07 with out_last=1.
- Pass-through:
  - Stimulus: same data, transpose=0.
  - Response: out_data sequence equals the input rows in order, 0x0706050403020100 first.
- Streaming:
  - Stimulus: 4 back-to-back blocks, in_valid=1 and out_ready=1 constantly.
  - Response: in_ready never drops after reset; 32 outputs arrive in 32 consecutive cycles starting at cycle 9. Block k of the outputs is the transpose of block k of the inputs.
- Back-pressure:
  - Stimulus: out_ready=0 while 16 rows are offered.
  - Response: in_ready drops after row 15 (both banks full); out_data is held at column 0 of block 0.
  - Then raise out_ready for 1 cycle: out_data changes to column 1. in_ready stays 0 until column 7 is consumed, then rises the next cycle.
- Mode latch:
  - Stimulus: toggle transpose to 0 while writing row 3 of a block started with transpose=1.
  - Response: that block is still output transposed; the next block, started with transpose=0, is output in pass-through order.
- Clear and reset mid-operation:
  - Stimulus: assert clear after 5 rows written while the other bank is half-drained.
  - Response: the next cycle shows out_valid=0, in_ready=1, out_data=0. A fresh block then yields correct output with no stale data.
  - Repeat with an async reset pulse between clock edges: outputs reach reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/dct_transpose_buf.sv
// dct_transpose_buf: ping-pong transpose buffer sitting between the row and
// column stages of the 2D-DCT. One bank fills with N rows while the other
// drains as N columns (or as the original rows in pass-through mode).
module dct_transpose_buf #(
    parameter int N      = 8,
    parameter int ELEM_W = 8,
    parameter int CW     = $clog2(N)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                transpose,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N*ELEM_W-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N*ELEM_W-1:0] out_data,
    output logic                out_last,
    output logic                out_first
);

    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    // Row storage for both banks; contents are only meaningful while the
    // matching full flag is set, so it carries no reset.
    logic [N*ELEM_W-1:0] bank_mem [2][N];

    logic [1:0]    full_q, full_d;
    logic [1:0]    mode_q, mode_d;
    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic [CW-1:0] wr_row_q, wr_row_d;
    logic [CW-1:0] rd_idx_q, rd_idx_d;
    logic          wr_fire;
    logic          rd_fire;

    // Handshake status: a bank is writable while empty and readable while
    // full, so reads and writes in the same cycle never touch the same bank.
    always_comb begin
        in_ready  = !full_q[wr_bank_q];
        out_valid = full_q[rd_bank_q];
        wr_fire   = in_valid && in_ready && !clear;
        rd_fire   = out_valid && out_ready && !clear;
        out_first = out_valid && (rd_idx_q == '0);
        out_last  = out_valid && (rd_idx_q == LAST_IDX);
    end

    // Next-state for bank flags and pointers; clear flushes everything and
    // discards any handshake happening in the same cycle.
    always_comb begin
        full_d    = full_q;
        mode_d    = mode_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_row_d  = wr_row_q;
        rd_idx_d  = rd_idx_q;
        if (clear) begin
            full_d    = '0;
            mode_d    = '0;
            wr_bank_d = 1'b0;
            rd_bank_d = 1'b0;
            wr_row_d  = '0;
            rd_idx_d  = '0;
        end else begin
            if (wr_fire) begin
                if (wr_row_q == '0) begin
                    mode_d[wr_bank_q] = transpose;
                end
                if (wr_row_q == LAST_IDX) begin
                    full_d[wr_bank_q] = 1'b1;
                    wr_bank_d         = !wr_bank_q;
                    wr_row_d          = '0;
                end else begin
                    wr_row_d = wr_row_q + 1'b1;
                end
            end
            if (rd_fire) begin
                if (rd_idx_q == LAST_IDX) begin
                    full_d[rd_bank_q] = 1'b0;
                    rd_bank_d         = !rd_bank_q;
                    rd_idx_d          = '0;
                end else begin
                    rd_idx_d = rd_idx_q + 1'b1;
                end
            end
        end
    end

    // Output vector: either a column gathered across all rows of the read
    // bank, or the stored row itself; zero whenever nothing is valid.
    always_comb begin
        out_data = '0;
        if (out_valid) begin
            if (mode_q[rd_bank_q]) begin
                for (int r = 0; r < N; r++) begin
                    out_data[r*ELEM_W +: ELEM_W] =
                        bank_mem[rd_bank_q][r][int'(rd_idx_q)*ELEM_W +: ELEM_W];
                end
            end else begin
                out_data = bank_mem[rd_bank_q][rd_idx_q];
            end
        end
    end

    // Capture each accepted row into the bank currently being filled.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            bank_mem[wr_bank_q][wr_row_q] <= in_data;
        end
    end

    // Bank flags and pointers, asynchronously reset to an empty buffer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_q    <= '0;
            mode_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_row_q  <= '0;
            rd_idx_q  <= '0;
        end else begin
            full_q    <= full_d;
            mode_q    <= mode_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_row_q  <= wr_row_d;
            rd_idx_q  <= rd_idx_d;
        end
    end

endmodule

// File: tb/tb_dct_transpose_buf.sv
// tb_dct_transpose_buf: table-driven and scoreboard-checked bench for the
// DCT ping-pong transpose buffer (N=8, 8-bit elements).
module tb_dct_transpose_buf;

    localparam int N  = 8;
    localparam int EW = 8;
    localparam int W  = N * EW;

    logic         clk       = 1'b0;
    logic         reset     = 1'b1;
    logic         clear     = 1'b0;
    logic         transpose = 1'b0;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] in_data   = '0;
    logic         in_ready;
    logic         out_valid;
    logic         out_last;
    logic         out_first;
    logic [W-1:0] out_data;

    typedef struct {
        logic [W-1:0] data;
        logic         first;
        logic         last;
    } exp_t;

    typedef struct {
        logic         tr;
        logic [7:0]   base;
        logic [W-1:0] expFirst;
        logic [W-1:0] expLast;
    } vec_t;

    exp_t         expQ[$];
    vec_t         vecTable[4];
    int           vecCount      = 0;
    int           missCount     = 0;
    int           cycle         = 0;
    int           stallCount    = 0;
    int           popCount      = 0;
    int           firstPopCycle = -1;
    int           lastPopCycle  = -1;
    int           firstInCycle  = -1;
    logic [W-1:0] capFirst      = '0;
    logic [W-1:0] capLast       = '0;

    dct_transpose_buf #(.N(N), .ELEM_W(EW)) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .transpose (transpose),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_first (out_first)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Cycle counter used for latency and throughput measurements.
    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] elem(input logic [7:0] base, input int r, input int c);
        return base + 8'(N * r + c);
    endfunction

    // Offer one row and hold it until the buffer accepts it.
    task automatic sendRow(input logic [W-1:0] data, input logic tr);
        int   waited   = 0;
        logic accepted = 1'b0;
        in_valid  = 1'b1;
        in_data   = data;
        transpose = tr;
        while (!accepted) begin
            @(negedge clk);
            accepted = in_ready;
            if (accepted && firstInCycle < 0) firstInCycle = cycle;
            if (!accepted) stallCount++;
            @(posedge clk);
            #1;
            if (!accepted) begin
                waited++;
                if (waited > 200) begin
                    checkOutput("sendRow timeout", W'(0), W'(1));
                    break;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    // Write 'rows' rows of a block with element(r,c)=base+8r+c; from row
    // toggleRow on the transpose input is inverted. A complete block pushes
    // its expected output vectors, using the row-0 transpose value.
    task automatic applyStimulus(input logic [7:0] base, input logic tr, input int toggleRow, input int rows);
        for (int r = 0; r < rows; r++) begin
            logic [W-1:0] row;
            for (int c = 0; c < N; c++) row[c*EW +: EW] = elem(base, r, c);
            sendRow(row, (r >= toggleRow) ? !tr : tr);
        end
        if (rows == N) begin
            for (int k = 0; k < N; k++) begin
                exp_t e;
                for (int j = 0; j < N; j++) begin
                    e.data[j*EW +: EW] = tr ? elem(base, j, k) : elem(base, k, j);
                end
                e.first = (k == 0);
                e.last  = (k == N - 1);
                expQ.push_back(e);
            end
        end
    endtask

    // Wait (bounded) until every expected vector has been seen.
    task automatic waitDrain();
        int budget = 0;
        while (expQ.size() != 0 && budget < 500) begin
            @(posedge clk);
            budget++;
        end
        checkOutput("drain queue empty", W'(expQ.size()), W'(0));
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every output handshake is compared against the queue head.
    always @(negedge clk) begin
        if (!reset && !clear && out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("spurious out_valid", W'(out_valid), W'(0));
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("out_data", out_data, e.data);
                checkOutput("out_first", W'(out_first), W'(e.first));
                checkOutput("out_last", W'(out_last), W'(e.last));
                if (out_first) capFirst = out_data;
                if (out_last) capLast = out_data;
                popCount++;
                if (firstPopCycle < 0) firstPopCycle = cycle;
                lastPopCycle = cycle;
            end
        end
    end

    // Hard stop in case something hangs beyond every local bound.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vecTable[0] = '{1'b1, 8'h00, 64'h3830282018100800, 64'h3F372F271F170F07};
        vecTable[1] = '{1'b0, 8'h00, 64'h0706050403020100, 64'h3F3E3D3C3B3A3938};
        vecTable[2] = '{1'b1, 8'h40, 64'h7870686058504840, 64'h7F776F675F574F47};
        vecTable[3] = '{1'b0, 8'h40, 64'h4746454443424140, 64'h7F7E7D7C7B7A7978};

        // Reset values while reset is asserted and just after release.
        #12;
        checkOutput("reset in_ready", W'(in_ready), W'(1));
        checkOutput("reset out_valid", W'(out_valid), W'(0));
        checkOutput("reset out_data", out_data, W'(0));
        checkOutput("reset out_first", W'(out_first), W'(0));
        checkOutput("reset out_last", W'(out_last), W'(0));
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("post-reset out_valid", W'(out_valid), W'(0));
        checkOutput("post-reset in_ready", W'(in_ready), W'(1));
        @(posedge clk);
        #1;

        // Single blocks from the table: transpose and pass-through.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecTable[i].base, vecTable[i].tr, N, N);
            @(negedge clk);
            checkOutput("latency out_valid", W'(out_valid), W'(1));
            checkOutput("latency out_first", W'(out_first), W'(1));
            waitDrain();
            checkOutput("table first vector", capFirst, vecTable[i].expFirst);
            checkOutput("table last vector", capLast, vecTable[i].expLast);
        end

        // Streaming: four back-to-back transposed blocks at full rate.
        stallCount    = 0;
        popCount      = 0;
        firstInCycle  = -1;
        firstPopCycle = -1;
        for (int b = 0; b < 4; b++) applyStimulus(8'(b * 16 + 3), 1'b1, N, N);
        waitDrain();
        checkOutput("stream in_ready stalls", W'(stallCount), W'(0));
        checkOutput("stream output count", W'(popCount), W'(32));
        checkOutput("stream no bubbles", W'(lastPopCycle - firstPopCycle), W'(31));
        checkOutput("stream first latency", W'(firstPopCycle - firstInCycle), W'(N));

        // Back-pressure: both banks fill while the output is stalled.
        out_ready = 1'b0;
        applyStimulus(8'h10, 1'b1, N, N);
        applyStimulus(8'h90, 1'b1, N, N);
        @(negedge clk);
        checkOutput("bp in_ready low", W'(in_ready), W'(0));
        checkOutput("bp hold col0", out_data, expQ[0].data);
        checkOutput("bp out_first held", W'(out_first), W'(1));
        repeat (3) @(negedge clk);
        checkOutput("bp col0 stable", out_data, expQ[0].data);
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        checkOutput("bp advance col1", out_data, expQ[0].data);
        checkOutput("bp col1 not first", W'(out_first), W'(0));
        checkOutput("bp in_ready still low", W'(in_ready), W'(0));
        @(posedge clk);
        #1 out_ready = 1'b1;
        for (int i = 1; i < N; i++) begin
            @(negedge clk);
            checkOutput("bp in_ready until col7", W'(in_ready), W'(0));
        end
        @(negedge clk);
        checkOutput("bp in_ready rises", W'(in_ready), W'(1));
        waitDrain();

        // Mode latch: transpose drops at row 3; only row 0 matters.
        applyStimulus(8'h20, 1'b1, 3, N);
        applyStimulus(8'h60, 1'b0, N, N);
        waitDrain();
        checkOutput("mode pass first row", capFirst, 64'h6766656463626160);

        // Synchronous clear with one bank half drained and one part written.
        out_ready = 1'b0;
        applyStimulus(8'h30, 1'b1, N, N);
        @(posedge clk);
        #1 out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        applyStimulus(8'h50, 1'b0, N, 5);
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        expQ.delete();
        @(negedge clk);
        checkOutput("clear out_valid", W'(out_valid), W'(0));
        checkOutput("clear in_ready", W'(in_ready), W'(1));
        checkOutput("clear out_data", out_data, W'(0));
        checkOutput("clear out_first", W'(out_first), W'(0));
        @(posedge clk);
        #1 out_ready = 1'b1;
        applyStimulus(8'hA0, 1'b1, N, N);
        waitDrain();
        checkOutput("clear fresh first", capFirst, 64'hD8D0C8C0B8B0A8A0);

        // Asynchronous reset pulse between clock edges.
        out_ready = 1'b0;
        applyStimulus(8'h70, 1'b0, N, N);
        applyStimulus(8'hC0, 1'b1, N, 3);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        checkOutput("async out_valid", W'(out_valid), W'(0));
        checkOutput("async in_ready", W'(in_ready), W'(1));
        checkOutput("async out_data", out_data, W'(0));
        checkOutput("async out_first", W'(out_first), W'(0));
        checkOutput("async out_last", W'(out_last), W'(0));
        expQ.delete();
        #3 reset = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b1;
        applyStimulus(8'hE0, 1'b0, N, N);
        waitDrain();
        checkOutput("async fresh first", capFirst, 64'hE7E6E5E4E3E2E1E0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
